// File: rtl/output_transform_stream_pkg.sv
// Shared types for the output transform stream: GF(2) byte matrix, isomorphism constants, FSM states.
package output_transform_stream_pkg;

  // Row r selects the input bits that XOR into output bit r (bit 0 = byte LSB).
  typedef logic [7:0][7:0] mm_matrix_t;

  // ISO_L is I + shift (y[r] = x[r] ^ x[r+1]); its inverse is the upper-triangular all-ones matrix.
  localparam mm_matrix_t ISO_L     = {8'h80, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03};
  localparam mm_matrix_t ISO_L_INV = {8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
  localparam mm_matrix_t MM_IDENT  = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StXform = 2'd1,
    StHold  = 2'd2
  } state_e;

endpackage

// File: rtl/matrix_mul.sv
// Byte times 8x8 GF(2) matrix, plus a constant affine offset d.
module matrix_mul
  import output_transform_stream_pkg::*;
#(
  parameter logic [7:0] d = 8'h00
) (
  input  mm_matrix_t i_m,
  input  logic [7:0] i_x,
  output logic [7:0] o_y
);

  always_comb begin
    o_y = d;
    for (int r = 0; r < 8; r++) begin
      o_y[r] = o_y[r] ^ (^(i_m[r] & i_x));
    end
  end

endmodule

// File: rtl/output_transform_stream.sv
// Converts a 16-byte block back to the standard field, BYTES_PER_CYCLE bytes per cycle.
// Optional macro OUT_XFORM_BYPASS_EN adds bypass_i (bytes pass through unchanged).
module output_transform_stream
  import output_transform_stream_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] block_i,
  input  mm_matrix_t   L_inv,
`ifdef OUT_XFORM_BYPASS_EN
  input  logic         bypass_i,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] block_o,
  output logic         busy
);

  localparam int unsigned NumChunks = 16 / BYTES_PER_CYCLE;
  localparam logic [3:0]  LastChunk = 4'(NumChunks - 1);

  state_e       r_state, w_state_next;
  logic [3:0]   r_cnt;
  logic [0:127] r_blk;
  logic [0:127] r_out;
  mm_matrix_t   r_mat;
  logic         w_accept;
  logic         w_bypass;
  logic [3:0]   w_byte_base;
  logic [3:0]   w_idx  [BYTES_PER_CYCLE];
  logic [7:0]   w_src  [BYTES_PER_CYCLE];
  logic [7:0]   w_conv [BYTES_PER_CYCLE];
  logic [7:0]   w_res  [BYTES_PER_CYCLE];

  assign w_byte_base = 4'(r_cnt * BYTES_PER_CYCLE);

  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
    assign w_idx[j] = w_byte_base + 4'(j);
    assign w_src[j] = r_blk[{w_idx[j], 3'b000} +: 8];

    matrix_mul #(
      .d(8'h00)
    ) u_matrix_mul (
      .i_m(r_mat),
      .i_x(w_src[j]),
      .o_y(w_conv[j])
    );

    assign w_res[j] = w_bypass ? w_src[j] : w_conv[j];
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_next = StXform;
      end
      StXform: begin
        if (r_cnt == LastChunk) w_state_next = StHold;
      end
      StHold: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        // Output and input handshakes may complete together: go straight back to XFORM.
        if (out_ready) w_state_next = in_valid ? StXform : StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign w_accept = in_valid & in_ready;
  assign block_o  = r_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_blk   <= '0;
      r_mat   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_blk <= block_i;
        r_mat <= L_inv;
        r_cnt <= '0;
      end else if (r_state == StXform) begin
        r_cnt <= r_cnt + 4'd1;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
          r_out[{w_idx[j], 3'b000} +: 8] <= w_res[j];
        end
      end
    end
  end

`ifdef OUT_XFORM_BYPASS_EN
  logic r_bypass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bypass <= 1'b0;
    end else if (w_accept) begin
      r_bypass <= bypass_i;
    end
  end

  assign w_bypass = r_bypass;
`else
  assign w_bypass = 1'b0;
`endif

endmodule

// File: tb/tb_output_transform_stream.sv
// Directed, table-driven bench for output_transform_stream (BYTES_PER_CYCLE = 4).
module tb_output_transform_stream;
  import output_transform_stream_pkg::*;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] block_i;
  mm_matrix_t   L_inv;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] block_o;
  logic         busy;
`ifdef OUT_XFORM_BYPASS_EN
  logic         bypass;
`endif

  int n_err;
  int n_chk;

  output_transform_stream #(
    .BYTES_PER_CYCLE(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .block_i  (block_i),
    .L_inv    (L_inv),
`ifdef OUT_XFORM_BYPASS_EN
    .bypass_i (bypass),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .block_o  (block_o),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  typedef struct {
    logic [127:0] blk;
    mm_matrix_t   mat;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Forward isomorphism written out directly: y[r] = x[r] ^ x[r+1], y[7] = x[7].
  function automatic logic [7:0] fwd_iso(input logic [7:0] x);
    logic [7:0] y;
    for (int r = 0; r < 7; r++) y[r] = x[r] ^ x[r+1];
    y[7] = x[7];
    return y;
  endfunction

  task automatic send(input logic [127:0] blk, input mm_matrix_t mat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("send_in_ready_timeout", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    block_i  = blk;
    L_inv    = mat;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  initial begin
    int   lat;
    logic seen;
    n_err     = 0;
    n_chk     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    block_i   = '0;
    L_inv     = '0;
`ifdef OUT_XFORM_BYPASS_EN
    bypass    = 1'b0;
`endif

    vecs[0] = '{blk: 128'h00112233445566778899AABBCCDDEEFF, mat: MM_IDENT,
                exp: 128'h00112233445566778899AABBCCDDEEFF};
    vecs[1] = '{blk: 128'h00018003FF105500018003FF10550001, mat: ISO_L_INV,
                exp: 128'h0001FF02AA1F660001FF02AA1F660001};
    vecs[2] = '{blk: 128'h0180FF5510000180FF5510000180FF55, mat: ISO_L,
                exp: 128'h01C0807F180001C0807F180001C0807F};
    vecs[3] = '{blk: {16{8'hFF}}, mat: '0, exp: '0};
    vecs[4] = '{blk: {16{8'h55}}, mat: ISO_L_INV, exp: {16{8'h66}}};

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_block_o", block_o, 128'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_in_ready", 128'(in_ready), 128'd1);

    // Table-driven vectors with out_ready held high.
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].blk, vecs[i].mat);
      wait_valid(lat);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
      check($sformatf("vec%0d_block_o", i), block_o, vecs[i].exp);
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid_drop", i), 128'(out_valid), 128'd0);
      check($sformatf("vec%0d_idle", i), 128'(busy), 128'd0);
    end

    // Round trip: forward isomorphism in the bench, inverse in the DUT.
    for (int v = 0; v < 256; v++) begin
      send({16{fwd_iso(8'(v))}}, ISO_L_INV);
      wait_valid(lat);
      check($sformatf("roundtrip_%02h", v), block_o, {16{8'(v)}});
      @(posedge clk); #1;
    end

    // Back-pressure: hold for 10 cycles.
    out_ready = 1'b0;
    send(128'h00112233445566778899AABBCCDDEEFF, MM_IDENT);
    wait_valid(lat);
    check("hold_latency", 128'(lat), 128'd4);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d_valid", k), 128'(out_valid), 128'd1);
      check($sformatf("hold%0d_block_o", k), block_o, 128'h00112233445566778899AABBCCDDEEFF);
      check($sformatf("hold%0d_in_ready", k), 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release_valid", 128'(out_valid), 128'd0);
    check("hold_release_busy", 128'(busy), 128'd0);

    // Matrix change after accept must not affect the in-flight block.
    send(128'hDEADBEEF0123456789ABCDEFFEDCBA98, MM_IDENT);
    L_inv = '0;
    wait_valid(lat);
    check("late_matrix_latency", 128'(lat), 128'd4);
    check("late_matrix_block_o", block_o, 128'hDEADBEEF0123456789ABCDEFFEDCBA98);
    @(posedge clk); #1;

    // Back-to-back: second block accepted in the HOLD handshake cycle.
    out_ready = 1'b0;
    send({16{8'hA5}}, MM_IDENT);
    wait_valid(lat);
    check("b2b_first_block_o", block_o, {16{8'hA5}});
    in_valid  = 1'b1;
    block_i   = {16{8'h80}};
    L_inv     = ISO_L_INV;
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_valid_dropped", 128'(out_valid), 128'd0);
    check("b2b_busy", 128'(busy), 128'd1);
    wait_valid(lat);
    check("b2b_second_latency", 128'(lat), 128'd4);
    check("b2b_second_block_o", block_o, {16{8'hFF}});
    @(posedge clk); #1;

    // Reset during chunk 2 abandons the block.
    send({16{8'h3C}}, MM_IDENT);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_block_o", block_o, 128'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("abort_in_ready", 128'(in_ready), 128'd1);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1'b1;
    end
    check("abort_no_output", 128'(seen), 128'd0);

`ifdef OUT_XFORM_BYPASS_EN
    bypass = 1'b1;
    send(128'h00018003FF105500018003FF10550001, ISO_L_INV);
    bypass = 1'b0;
    wait_valid(lat);
    check("bypass_latency", 128'(lat), 128'd4);
    check("bypass_block_o", block_o, 128'h00018003FF105500018003FF10550001);
    @(posedge clk); #1;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/output_transform_stream.md
OUTPUT_TRANSFORM_STREAM -- requirements
Module: output_transform_stream

Interface
REQ-001 SHALL have parameter BYTES_PER_CYCLE, default 4, number of bytes converted per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  block_i holds a valid isomorphic-field block.
REQ-005 SHALL have port in_ready  output  1  module accepts a block this cycle.
REQ-006 SHALL have port block_i  input  [0:127]  16 bytes in the isomorphic field; byte k = bits [8k:8k+7].
REQ-007 SHALL have port L_inv  input  mm_matrix_t  inverse isomorphism matrix, returns bytes to the standard field.
REQ-008 SHALL have port out_valid  output  1  block_o holds a converted block.
REQ-009 SHALL have port out_ready  input  1  downstream accepts block_o this cycle.
REQ-010 SHALL have port block_o  output  [0:127]  converted block, same byte ordering as block_i.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, XFORM, HOLD.
REQ-013 SHALL set in_ready = (state==IDLE) or (state==HOLD and out_ready).
REQ-014 SHALL, on accept (in_valid and in_ready), register block_i and L_inv, clear chunk counter, enter XFORM.
REQ-015 SHALL use only the registered L_inv for the whole block; L_inv changes after accept have no effect on it.
REQ-016 SHALL, in each XFORM cycle with counter c, write bytes c*BYTES_PER_CYCLE .. c*BYTES_PER_CYCLE+BYTES_PER_CYCLE-1 of block_o as registered byte times registered L_inv over GF(2), then increment c.
REQ-017 SHALL leave XFORM for HOLD after chunk 16/BYTES_PER_CYCLE-1; out_valid goes high the following cycle. Latency from accept edge to out_valid = 16/BYTES_PER_CYCLE cycles.
REQ-018 SHALL keep block_o and out_valid stable in HOLD until out_ready is high.
REQ-019 SHALL, on out_ready in HOLD without new in_valid, drop out_valid and return to IDLE next cycle.
REQ-020 SHALL, on out_ready and in_valid in the same HOLD cycle, complete both handshakes and enter XFORM directly, with no idle cycle.
REQ-021 SHALL ignore in_valid in XFORM, where in_ready is low.
REQ-022 SHALL produce block_o bytes not yet overwritten in XFORM as don't-care; out_valid stays low throughout XFORM.

Reset
REQ-023 SHALL, while rst is high, immediately force state IDLE, counter 0, out_valid 0, busy 0, block_o all zero, registered block and matrix zero; in_ready is 1 after release.
REQ-024 SHALL abandon any block in XFORM or HOLD when reset is asserted mid-operation, with no output produced for it.

Configuration
REQ-025 SHALL, with macro OUT_XFORM_BYPASS_EN defined, add port bypass_i (input, 1), registered at accept; when it is 1, each byte passes unchanged, with identical latency and handshake.
REQ-026 SHALL, without OUT_XFORM_BYPASS_EN, have no bypass_i port and always apply L_inv.

Structure
REQ-027 SHALL take mm_matrix_t and constants ISO_L and ISO_L_INV (the isomorphism matrix and its inverse) from the shared types package; the state enum belongs in the same package.
REQ-028 SHALL instantiate BYTES_PER_CYCLE copies of matrix_mul with d=0 as the byte converters; no other sub-module.

Verification
REQ-029 SHALL check: BYTES_PER_CYCLE=4, L_inv=identity, block_i=0x00112233445566778899AABBCCDDEEFF, out_ready=1 -> same value on block_o, out_valid exactly 4 cycles after accept, then low 1 cycle later.
REQ-030 SHALL check: round trip through input_transform with ISO_L and then this block with ISO_L_INV, on all 256 byte values replicated across 16 bytes (e.g. 0x53 in every byte) -> block_o equals the original bytes.
REQ-031 SHALL check: out_ready held 0 for 10 cycles in HOLD -> block_o and out_valid constant, in_ready 0; out_ready=1 -> handshake completes.
REQ-032 SHALL check: L_inv changed to all-zero one cycle after accept with identity registered -> output still equals input.
REQ-033 SHALL check: back-to-back blocks, in_valid=1 during the out_ready cycle in HOLD -> second block accepted the same cycle, out_valid for it 4 cycles later.
REQ-034 SHALL check: rst pulsed during XFORM chunk 2 -> out_valid 0 and busy 0 immediately, in_ready 1 after release, no output for the aborted block.
